// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline-stage register with a valid/ready handshake,
// optional two-entry skid buffer, flush and bubble insertion. The first user is
// IF->ID, where the payload is {pc, inst}.
//
// Parameters
//   DATA_W     payload width in bits
//   SKID       1: two-entry skid buffer, up_ready_out is a function of registered
//                 state only
//              0: single register, up_ready_out = !dn_valid_out | dn_ready_in
//   NOP_VALUE  value presented on dn_data_out whenever no valid entry is held
//
// Ports
//   clk_in        clock, all state changes on the rising edge
//   rst_in        synchronous active-high reset
//   flush_in      drop all held entries and the current upstream transfer
//   up_valid_in   upstream offers up_data_in
//   up_ready_out  stage can accept this cycle
//   up_data_in    upstream payload
//   dn_valid_out  dn_data_out holds a valid entry
//   dn_ready_in   downstream consumes this cycle
//   dn_data_out   head entry, NOP_VALUE when invalid
//   count_out     occupancy 0..2 (0..1 when SKID=0)
module pipe_stage_buf #(
  parameter int unsigned       DATA_W    = 64,
  parameter bit                SKID      = 1'b1,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              up_valid_in,
  output logic              up_ready_out,
  input  logic [DATA_W-1:0] up_data_in,
  output logic              dn_valid_out,
  input  logic              dn_ready_in,
  output logic [DATA_W-1:0] dn_data_out,
  output logic [1:0]        count_out
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              pop;

  // Handshake and status outputs.
  always_comb begin
    if (SKID) begin
      up_ready_out = (state_q != FULL);
    end else begin
      up_ready_out = (state_q == EMPTY) | dn_ready_in;
    end
    dn_valid_out = (state_q != EMPTY);
    count_out    = state_q;
    // main_q is forced to NOP_VALUE whenever the stage empties, so the head
    // register can drive the output directly without a bubble mux.
    dn_data_out  = main_q;
    accept       = up_valid_in & up_ready_out;
    pop          = dn_valid_out & dn_ready_in;
  end

  // Next-state logic. Flush overrides the handshake; a pop in the flush cycle
  // has already been consumed downstream and needs no further action.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_in) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = up_data_in;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = up_data_in;
          end else if (accept) begin
            // Only reachable with SKID=1: with SKID=0 a held entry makes
            // up_ready_out equal dn_ready_in, so accept implies pop.
            state_d = FULL;
            skid_d  = up_data_in;
          end else if (pop) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf. Two instances share one stimulus:
// dut_s (SKID=1, NOP=0) and dut_z (SKID=0, non-zero NOP). Each instance has a
// queue-based reference model that applies the reset/flush/accept/pop rules.
module tb_pipe_stage_buf;

  localparam logic [63:0] NOP_S = 64'h0;
  localparam logic [63:0] NOP_Z = 64'h0000_0000_0000_0013;
  localparam logic [63:0] SEQ   = 64'hA000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst, flush, up_valid, dn_ready;
  logic [63:0] up_data;

  logic        s_ready, s_valid;
  logic [63:0] s_data;
  logic [1:0]  s_count;
  logic        z_ready, z_valid;
  logic [63:0] z_data;
  logic [1:0]  z_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] qs[$];
  logic [63:0] qz[$];
  bit          m_acc_s, m_pop_s, m_acc_z, m_pop_z;
  logic [63:0] pa, pb, pc, pd;

  pipe_stage_buf #(.DATA_W(64), .SKID(1'b1), .NOP_VALUE(NOP_S)) dut_s (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .up_valid_in(up_valid), .up_ready_out(s_ready), .up_data_in(up_data),
    .dn_valid_out(s_valid), .dn_ready_in(dn_ready), .dn_data_out(s_data),
    .count_out(s_count)
  );

  pipe_stage_buf #(.DATA_W(64), .SKID(1'b0), .NOP_VALUE(NOP_Z)) dut_z (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .up_valid_in(up_valid), .up_ready_out(z_ready), .up_data_in(up_data),
    .dn_valid_out(z_valid), .dn_ready_in(dn_ready), .dn_data_out(z_data),
    .count_out(z_count)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid).
  always @(posedge clk) begin
    m_acc_s = up_valid && (qs.size() < 2);
    m_pop_s = (qs.size() != 0) && dn_ready;
    m_acc_z = up_valid && ((qz.size() == 0) || dn_ready);
    m_pop_z = (qz.size() != 0) && dn_ready;
    if (rst || flush) begin
      qs.delete();
      qz.delete();
    end else begin
      if (m_pop_s) void'(qs.pop_front());
      if (m_acc_s) qs.push_back(up_data);
      if (m_pop_z) void'(qz.pop_front());
      if (m_acc_z) qz.push_back(up_data);
    end
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] head_s();
    if (qs.size() == 0) return NOP_S;
    return qs[0];
  endfunction

  function automatic logic [63:0] head_z();
    if (qz.size() == 0) return NOP_Z;
    return qz[0];
  endfunction

  // Drive one cycle of inputs after the falling edge; outputs are then
  // observed 1 time unit later, well away from the rising edge.
  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [63:0] d, input logic rd);
    @(negedge clk);
    rst      = r;
    flush    = f;
    up_valid = v;
    up_data  = d;
    dn_ready = rd;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, rnd64(), 1'b1);
      checks++;
      if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_s_valid got %b exp 0", s_valid); end
      checks++;
      if (s_data !== NOP_S) begin errors++; $display("FAIL rst_s_data got %h exp %h", s_data, NOP_S); end
      checks++;
      if (s_count !== 2'd0) begin errors++; $display("FAIL rst_s_count got %0d exp 0", s_count); end
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got %b exp 1", s_ready); end
      checks++;
      if (z_valid !== 1'b0 || z_data !== NOP_Z) begin
        errors++; $display("FAIL rst_z got %b/%h exp 0/%h", z_valid, z_data, NOP_Z);
      end
    end
  endtask

  task automatic test_stream();
    logic [63:0] d0, d1;
    logic [63:0] ed [4];
    logic        ev [4];
    d0 = 64'h1000_0000_0000_0013;
    d1 = 64'h1004_0000_0010_0093;
    ed = '{64'h0, d0, d1, 64'h0};
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i < 2, (i == 0) ? d0 : ((i == 1) ? d1 : rnd64()), 1'b1);
      checks++;
      if (s_valid !== ev[i] || s_data !== ed[i]) begin
        errors++; $display("FAIL stream_s[%0d] got %b/%h exp %b/%h", i, s_valid, s_data, ev[i], ed[i]);
      end
      checks++;
      if (s_count !== {1'b0, ev[i]}) begin
        errors++; $display("FAIL stream_s_count[%0d] got %0d exp %0d", i, s_count, ev[i]);
      end
      checks++;
      if (z_valid !== ev[i] || z_data !== (ev[i] ? ed[i] : NOP_Z) || z_count !== {1'b0, ev[i]}) begin
        errors++; $display("FAIL stream_z[%0d] got %b/%h/%0d exp %b/%h", i, z_valid, z_data, z_count,
                           ev[i], ev[i] ? ed[i] : NOP_Z);
      end
    end
  endtask

  task automatic test_backpressure_fill();
    logic [63:0] exd [4];
    logic [1:0]  exc [4];
    logic        exr [4];
    pa = rnd64(); pb = rnd64(); pc = rnd64();
    exd = '{NOP_S, pa, pa, pa};
    exc = '{2'd0, 2'd1, 2'd2, 2'd2};
    exr = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, (i == 0) ? pa : ((i == 1) ? pb : pc), 1'b0);
      checks++;
      if (s_data !== exd[i] || s_count !== exc[i]) begin
        errors++; $display("FAIL fill_s[%0d] got %h/%0d exp %h/%0d", i, s_data, s_count, exd[i], exc[i]);
      end
      checks++;
      if (s_ready !== exr[i]) begin
        errors++; $display("FAIL fill_s_ready[%0d] got %b exp %b", i, s_ready, exr[i]);
      end
      checks++;
      if (z_data !== head_z() || z_ready !== (qz.size() == 0)) begin
        errors++; $display("FAIL fill_z[%0d] got %h/%b exp %h/%b", i, z_data, z_ready, head_z(), qz.size() == 0);
      end
    end
  endtask

  task automatic test_drain();
    logic [63:0] exd [4];
    logic [1:0]  exc [4];
    logic        exv [4];
    exd = '{pa, pb, pc, NOP_S};
    exc = '{2'd2, 2'd1, 2'd1, 2'd0};
    exv = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, i < 2, (i < 2) ? pc : rnd64(), 1'b1);
      checks++;
      if (s_valid !== exv[i] || s_data !== exd[i] || s_count !== exc[i]) begin
        errors++; $display("FAIL drain_s[%0d] got %b/%h/%0d exp %b/%h/%0d", i, s_valid, s_data, s_count,
                           exv[i], exd[i], exc[i]);
      end
      checks++;
      if (z_data !== head_z()) begin
        errors++; $display("FAIL drain_z[%0d] got %h exp %h", i, z_data, head_z());
      end
    end
  endtask

  task automatic test_flush();
    pa = rnd64(); pd = rnd64();
    drive(1'b0, 1'b0, 1'b1, pa, 1'b0);
    drive(1'b0, 1'b1, 1'b1, pd, 1'b0);
    checks++;
    if (s_data !== pa || s_count !== 2'd1) begin
      errors++; $display("FAIL flush_pre got %h/%0d exp %h/1", s_data, s_count, pa);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, rnd64(), 1'b1);
      checks++;
      if (s_valid !== 1'b0 || s_data !== NOP_S || s_count !== 2'd0 || s_ready !== 1'b1) begin
        errors++; $display("FAIL flush_s[%0d] got %b/%h/%0d/%b exp 0/%h/0/1", i, s_valid, s_data, s_count,
                           s_ready, NOP_S);
      end
      checks++;
      if (z_valid !== 1'b0 || z_data !== NOP_Z || z_count !== 2'd0) begin
        errors++; $display("FAIL flush_z[%0d] got %b/%h/%0d exp 0/%h/0", i, z_valid, z_data, z_count, NOP_Z);
      end
    end
  endtask

  task automatic test_reset_mid();
    pa = rnd64(); pb = rnd64();
    drive(1'b0, 1'b0, 1'b1, pa, 1'b0);
    drive(1'b0, 1'b0, 1'b1, pb, 1'b0);
    drive(1'b0, 1'b0, 1'b0, rnd64(), 1'b0);
    checks++;
    if (s_count !== 2'd2 || s_data !== pa) begin
      errors++; $display("FAIL rmid_full got %0d/%h exp 2/%h", s_count, s_data, pa);
    end
    drive(1'b1, 1'b0, 1'b1, rnd64(), 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, rnd64(), 1'b1);
      checks++;
      if (s_valid !== 1'b0 || s_data !== NOP_S || s_count !== 2'd0 || s_ready !== 1'b1) begin
        errors++; $display("FAIL rmid_s[%0d] got %b/%h/%0d/%b exp 0/%h/0/1", i, s_valid, s_data, s_count,
                           s_ready, NOP_S);
      end
      checks++;
      if (z_valid !== 1'b0 || z_data !== NOP_Z) begin
        errors++; $display("FAIL rmid_z[%0d] got %b/%h exp 0/%h", i, z_valid, z_data, NOP_Z);
      end
    end
  endtask

  task automatic test_skid0_throughput();
    int unsigned next_push;
    int unsigned next_pop;
    logic        rd;
    logic        prev_stall;
    logic [63:0] prev_data;
    next_push  = 0;
    next_pop   = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    drive(1'b1, 1'b0, 1'b0, rnd64(), 1'b0);
    for (int i = 0; i < 16; i++) begin
      rd = (i % 2 == 0);
      drive(1'b0, 1'b0, 1'b1, SEQ + 64'(next_push), rd);
      checks++;
      if (z_ready !== (!(qz.size() != 0) || rd)) begin
        errors++; $display("FAIL tp_ready[%0d] got %b exp %b", i, z_ready, (qz.size() == 0) || rd);
      end
      checks++;
      if (z_count !== 2'(qz.size())) begin
        errors++; $display("FAIL tp_count[%0d] got %0d exp %0d", i, z_count, qz.size());
      end
      if (prev_stall) begin
        checks++;
        if (z_data !== prev_data) begin
          errors++; $display("FAIL tp_stable[%0d] got %h exp %h", i, z_data, prev_data);
        end
      end
      if (z_valid && rd) begin
        checks++;
        if (z_data !== SEQ + 64'(next_pop)) begin
          errors++; $display("FAIL tp_order[%0d] got %h exp %h", i, z_data, SEQ + 64'(next_pop));
        end
        next_pop++;
      end
      if (qz.size() == 0 || rd) next_push++;
      prev_stall = z_valid && !rd;
      prev_data  = z_data;
    end
    checks++;
    if (next_pop < 7) begin
      errors++; $display("FAIL tp_pops got %0d exp >= 7", next_pop);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
            rnd64(), $urandom_range(0, 2) != 0);
      checks++;
      if (s_valid !== (qs.size() != 0) || s_data !== head_s() || s_count !== 2'(qs.size())
          || s_ready !== (qs.size() < 2)) begin
        errors++; $display("FAIL rand_s[%0d] got %b/%h/%0d/%b exp %b/%h/%0d/%b", i, s_valid, s_data, s_count,
                           s_ready, qs.size() != 0, head_s(), qs.size(), qs.size() < 2);
      end
      checks++;
      if (z_valid !== (qz.size() != 0) || z_data !== head_z() || z_count !== 2'(qz.size())
          || z_ready !== ((qz.size() == 0) || dn_ready)) begin
        errors++; $display("FAIL rand_z[%0d] got %b/%h/%0d/%b exp %b/%h/%0d/%b", i, z_valid, z_data, z_count,
                           z_ready, qz.size() != 0, head_z(), qz.size(), (qz.size() == 0) || dn_ready);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    up_valid = 1'b0;
    up_data  = '0;
    dn_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure_fill();
    test_drain();
    test_flush();
    test_reset_mid();
    test_skid0_throughput();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
